// File: rtl/detector_jogada.sv
// Button conditioning for jogo_mindfocus: synchronizes and debounces the raw
// buttons and turns a stable single-button press into one clean move event.
module detector_jogada #(
  parameter int N_BOTOES   = 4,
  parameter int DEBOUNCE   = 20,
  parameter int LONG_PRESS = 3000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_valida,
  output logic                tem_jogada,
  output logic                pressao_longa,
  output logic                erro_multiplo,
  output logic [1:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int LW = $clog2(LONG_PRESS) + 1;
  localparam logic [CW-1:0]       CONT_UM    = CW'(1);
  localparam logic [CW-1:0]       CONT_FIM   = CW'(DEBOUNCE - 1);
  localparam logic [LW-1:0]       LONGO_UM   = LW'(1);
  localparam logic [LW-1:0]       LONGO_MAX  = LW'(LONG_PRESS);
  localparam logic [LW-1:0]       LONGO_PRE  = LW'(LONG_PRESS - 1);
  localparam logic [N_BOTOES-1:0] PADRAO_UM  = N_BOTOES'(1);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  estado_t             estado_q;
  logic [N_BOTOES-1:0] sync1_q;
  logic [N_BOTOES-1:0] s_q;
  logic [N_BOTOES-1:0] padrao_q;
  logic [CW-1:0]       cont_q;
  logic [LW-1:0]       cont_longo_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                valida_q;
  logic                tem_q;
  logic                longa_q;
  logic                erro_q;

  function automatic logic um_so(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - PADRAO_UM)) == '0);
  endfunction

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= botoes;
      s_q     <= sync1_q;
    end
  end

  // Debounce FSM with registered move outputs and single-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      padrao_q     <= '0;
      cont_q       <= '0;
      cont_longo_q <= '0;
      jogada_q     <= '0;
      valida_q     <= 1'b0;
      tem_q        <= 1'b0;
      longa_q      <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      valida_q <= 1'b0;
      longa_q  <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (s_q != '0) begin
            estado_q <= FILTRANDO;
            padrao_q <= s_q;
            cont_q   <= '0;
          end
        end
        FILTRANDO: begin
          if (s_q == '0) begin
            estado_q <= OCIOSO;
          end else if (s_q != padrao_q) begin
            padrao_q <= s_q;
            cont_q   <= '0;
          end else if (cont_q < CONT_FIM) begin
            cont_q <= cont_q + CONT_UM;
          end else begin
            cont_q <= '0;
            if (!um_so(padrao_q)) begin
              estado_q <= SOLTANDO;
              erro_q   <= 1'b1;
            end else if (habilita) begin
              estado_q     <= PRESSIONADO;
              jogada_q     <= padrao_q;
              valida_q     <= 1'b1;
              tem_q        <= 1'b1;
              cont_longo_q <= '0;
            end else begin
              estado_q <= SOLTANDO;
            end
          end
        end
        PRESSIONADO: begin
          if (s_q == padrao_q) begin
            // Saturation at LONG_PRESS keeps the hold pulse to one per press.
            if (cont_longo_q < LONGO_MAX) begin
              cont_longo_q <= cont_longo_q + LONGO_UM;
            end
            if (cont_longo_q == LONGO_PRE) begin
              longa_q <= 1'b1;
            end
          end else begin
            estado_q <= SOLTANDO;
            cont_q   <= '0;
            tem_q    <= 1'b0;
          end
        end
        SOLTANDO: begin
          if (s_q != '0) begin
            cont_q <= '0;
          end else if (cont_q < CONT_FIM) begin
            cont_q <= cont_q + CONT_UM;
          end else begin
            estado_q <= OCIOSO;
          end
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign jogada        = jogada_q;
  assign jogada_valida = valida_q;
  assign tem_jogada    = tem_q;
  assign pressao_longa = longa_q;
  assign erro_multiplo = erro_q;
  assign db_estado     = estado_q;

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Upstream input stage of jogo_mindfocus. Conditions the four raw player buttons into one clean, debounced move event.
- Synchronizes and debounces the raw `botoes` vector and checks that exactly one button is pressed.
- Outputs: the latched move code, a single-cycle `jogada_valida` pulse, a `tem_jogada` level, and a single-cycle long-press pulse used as the "voltar"/hold gesture.
- Runs on the game's 1 kHz clock (1 ms period), so all counts below are in milliseconds.

Parameters:
- N_BOTOES, 4, width of the button vector.
- DEBOUNCE, 20, number of consecutive stable synchronized samples required to commit a press or a release.
- LONG_PRESS, 3000, cycles in PRESSIONADO before `pressao_longa` pulses.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- botoes  in  N_BOTOES  raw asynchronous buttons, 1 = pressed.
- habilita  in  1  when 1, a committed single-button press is accepted as a move.
- jogada  out  N_BOTOES  one-hot code of the last accepted move; holds until the next accepted move.
- jogada_valida  out  1  one-cycle pulse when `jogada` is updated.
- tem_jogada  out  1  high while in PRESSIONADO.
- pressao_longa  out  1  one-cycle pulse after LONG_PRESS cycles in PRESSIONADO.
- erro_multiplo  out  1  one-cycle pulse when a stable multi-button pattern is committed.
- db_estado  out  2  current FSM state code.

Behaviour:
- Synchronizer: two flops, sync1 <= botoes and s <= sync1. The FSM acts only on s.
- Registers and reset values:
  - sync1, s = 0.
  - padrao (captured pattern) = 0.
  - cont (debounce counter, width clog2(DEBOUNCE)+1) = 0.
  - cont_longo (width clog2(LONG_PRESS)+1) = 0.
  - State = OCIOSO.
  - All outputs = 0.
- States: OCIOSO=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3.
- OCIOSO:
  - s != 0: go to FILTRANDO, padrao <= s, cont <= 0.
- FILTRANDO:
  - s == 0: go to OCIOSO.
  - s != padrao (nonzero): padrao <= s, cont <= 0, stay.
  - s == padrao and cont < DEBOUNCE-1: cont++.
  - s == padrao and cont == DEBOUNCE-1 (commit): choose one branch:
    - padrao one-hot and habilita=1: go to PRESSIONADO, jogada <= padrao, jogada_valida=1 for the next cycle, cont_longo <= 0.
    - padrao not one-hot: go to SOLTANDO, erro_multiplo pulses, jogada unchanged.
    - padrao one-hot and habilita=0: go to SOLTANDO, no pulse.
- PRESSIONADO:
  - s == padrao: cont_longo++ saturating at LONG_PRESS.
  - On the edge where cont_longo == LONG_PRESS-1: pressao_longa pulses for one cycle. It fires at most once per press.
  - s != padrao (release, or another button added): go to SOLTANDO, cont <= 0.
- SOLTANDO:
  - s != 0: cont <= 0, stay.
  - s == 0 and cont < DEBOUNCE-1: cont++.
  - s == 0 and cont == DEBOUNCE-1: go to OCIOSO.
  - A new move is never accepted without a full debounced release.
- Latency: if the raw press is first sampled at edge k and held stable, jogada_valida is high in the cycle after edge k+DEBOUNCE+2. With the default DEBOUNCE, that is 22 cycles.
- tem_jogada == (state == PRESSIONADO), registered.
- All pulses are exactly one cycle wide. jogada_valida, erro_multiplo and pressao_longa are mutually exclusive in any cycle.
- habilita is sampled only at the commit edge. Changing it while in PRESSIONADO has no effect.
- Reset mid-operation:
  - Returns to OCIOSO and clears jogada.
  - A button still held after reset is re-filtered and produces a fresh jogada_valida after DEBOUNCE+2 cycles.
- Glitch rejection: any bounce shorter than DEBOUNCE samples inside FILTRANDO restarts the count and never produces a pulse.

Test Plan:
1. Reset, habilita=1, botoes=4'b1000 held 10000 cycles then released:
   - jogada_valida pulses exactly once, 22 cycles after the first sampling edge.
   - jogada=4'b1000.
   - tem_jogada high until 3 cycles after release.
   - pressao_longa pulses once at press+22+3000 cycles.
   - State returns to OCIOSO 22 cycles after release.
2. botoes=4'b0010 toggled every 5 cycles for 200 cycles, then held 50 cycles:
   - No pulse during the toggling.
   - One jogada_valida 22 cycles after the hold begins.
   - jogada=4'b0010.
3. botoes=4'b0101 held 100 cycles:
   - erro_multiplo pulses once.
   - No jogada_valida; jogada keeps its previous value.
   - tem_jogada stays 0.
4. habilita=0, botoes=4'b0001 held 100 cycles:
   - No pulse and jogada unchanged.
   - After release and 22 idle cycles, set habilita=1 and press 4'b0001: jogada_valida pulses and jogada=4'b0001.
5. Press 4'b0100 to PRESSIONADO, then add 4'b0001 (botoes=4'b0101) and hold:
   - Goes to SOLTANDO with no new pulse.
   - No move is accepted until botoes=0 for 20 stable samples.
6. Assert reset for 1 cycle while in PRESSIONADO with the button held:
   - All outputs read 0 after the reset edge.
   - jogada_valida fires again 22 cycles after reset deasserts.
